// File: rtl/jbuffer_fifo.sv
// jbuffer_fifo: single-clock ready/valid FIFO with a registered storage array.
//
// Parameters
//   WIDTH     data width in bits (>= 1)
//   DEPTH     number of entries (power of two, >= 2)
//
// Ports
//   clk       rising-edge clock for all state
//   rst_n     synchronous active-low reset (clears pointers and count only)
//   in_data   write data
//   in_valid  write request
//   in_ready  buffer can accept a word this cycle (combinational from state)
//   out_data  head-of-buffer data, zero when empty
//   out_valid head word is valid
//   out_ready consumer accepts the head word
//   count     number of words currently held
module jbuffer_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic push_c;
  logic pop_c;

  // Handshake qualifiers; in_ready already folds in rst_n so nothing is written in reset.
  always_comb begin
    in_ready  = rst_n && (count_q != CW'(DEPTH));
    out_valid = (count_q != '0);
    out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
    count     = count_q;
    push_c    = in_valid && in_ready;
    pop_c     = out_valid && out_ready && rst_n;
  end

  // Next-state for pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_c) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array is intentionally not reset.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

endmodule

// File: tb/tb_jbuffer_fifo.sv
// Directed self-checking bench for jbuffer_fifo (WIDTH=8, DEPTH=4).
module tb_jbuffer_fifo;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] count;

  int tests_run;
  int fails;

  jbuffer_fifo #(.WIDTH(8), .DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; in_data = 8'hEE; out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      tests_run++;
      if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready cyc%0d: got %b exp 0", i, in_ready); end
    end
    tests_run++;
    if (count !== 3'd0) begin fails++; $display("FAIL reset_count: got %0d exp 0", count); end
    tests_run++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
    tests_run++;
    if (out_data !== 8'h00) begin fails++; $display("FAIL reset_out_data: got %h exp 00", out_data); end
    in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_release_in_ready: got %b exp 1", in_ready); end
  endtask

  task automatic test_fill_drain();
    logic [7:0] vals [4];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
    in_valid = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_data = vals[i];
      step();
    end
    tests_run++;
    if (count !== 3'd4) begin fails++; $display("FAIL fill_count: got %0d exp 4", count); end
    tests_run++;
    if (in_ready !== 1'b0) begin fails++; $display("FAIL fill_in_ready: got %b exp 0", in_ready); end
    in_data = 8'h55;
    step();
    tests_run++;
    if (count !== 3'd4) begin fails++; $display("FAIL fill_overflow_count: got %0d exp 4", count); end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (out_valid !== 1'b1 || out_data !== vals[i]) begin
        fails++; $display("FAIL drain_word%0d: got v=%b d=%h exp v=1 d=%h", i, out_valid, out_data, vals[i]);
      end
      step();
    end
    tests_run++;
    if (count !== 3'd0 || out_valid !== 1'b0 || out_data !== 8'h00) begin
      fails++; $display("FAIL drain_empty: got c=%0d v=%b d=%h exp c=0 v=0 d=00", count, out_valid, out_data);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_wrap();
    in_valid = 1'b1; out_ready = 1'b1; in_data = 8'h00;
    step();
    for (int k = 1; k < 10; k++) begin
      in_data = 8'(k);
      tests_run++;
      if (count !== 3'd1 || out_data !== 8'(k - 1)) begin
        fails++; $display("FAIL wrap_word%0d: got c=%0d d=%h exp c=1 d=%h", k - 1, count, out_data, 8'(k - 1));
      end
      step();
    end
    in_valid = 1'b0;
    tests_run++;
    if (out_data !== 8'h09) begin fails++; $display("FAIL wrap_last: got %h exp 09", out_data); end
    step();
    tests_run++;
    if (count !== 3'd0) begin fails++; $display("FAIL wrap_end_count: got %0d exp 0", count); end
    out_ready = 1'b0;
  endtask

  task automatic test_full_pop();
    logic [7:0] exp_q [3];
    exp_q[0] = 8'hA2; exp_q[1] = 8'hA3; exp_q[2] = 8'hB1;
    in_valid = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'hA0 + 8'(i);
      step();
    end
    in_data = 8'hB0; out_ready = 1'b1;
    tests_run++;
    if (in_ready !== 1'b0 || out_data !== 8'hA0) begin
      fails++; $display("FAIL fullpop_pre: got rdy=%b d=%h exp rdy=0 d=a0", in_ready, out_data);
    end
    step();
    tests_run++;
    if (count !== 3'd3 || in_ready !== 1'b1 || out_data !== 8'hA1) begin
      fails++; $display("FAIL fullpop_pop_only: got c=%0d rdy=%b d=%h exp c=3 rdy=1 d=a1", count, in_ready, out_data);
    end
    in_data = 8'hB1;
    step();
    tests_run++;
    if (count !== 3'd3 || out_data !== 8'hA2) begin
      fails++; $display("FAIL fullpop_pushpop: got c=%0d d=%h exp c=3 d=a2", count, out_data);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (out_data !== exp_q[i]) begin fails++; $display("FAIL fullpop_drain%0d: got %h exp %h", i, out_data, exp_q[i]); end
      step();
    end
    tests_run++;
    if (count !== 3'd0) begin fails++; $display("FAIL fullpop_end_count: got %0d exp 0", count); end
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b0;
    step();
    in_valid = 1'b0; in_data = 8'h00;
    for (int i = 0; i < 5; i++) begin
      step();
      tests_run++;
      if (out_valid !== 1'b1 || out_data !== 8'hA5) begin
        fails++; $display("FAIL backpressure_hold%0d: got v=%b d=%h exp v=1 d=a5", i, out_valid, out_data);
      end
    end
    out_ready = 1'b1;
    step();
    tests_run++;
    if (count !== 3'd0 || out_valid !== 1'b0) begin
      fails++; $display("FAIL backpressure_pop: got c=%0d v=%b exp c=0 v=0", count, out_valid);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_midop_reset();
    in_valid = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_data = 8'hC1 + 8'(i);
      step();
    end
    tests_run++;
    if (count !== 3'd3) begin fails++; $display("FAIL midrst_pre_count: got %0d exp 3", count); end
    rst_n = 1'b0; in_data = 8'hDD; out_ready = 1'b1;
    step();
    tests_run++;
    if (count !== 3'd0 || out_valid !== 1'b0 || out_data !== 8'h00 || in_ready !== 1'b0) begin
      fails++; $display("FAIL midrst_state: got c=%0d v=%b d=%h rdy=%b exp c=0 v=0 d=00 rdy=0",
                        count, out_valid, out_data, in_ready);
    end
    rst_n = 1'b1; in_data = 8'h7E; out_ready = 1'b0;
    step();
    in_data = 8'h3C;
    step();
    in_valid = 1'b0;
    tests_run++;
    if (count !== 3'd2 || out_data !== 8'h7E) begin
      fails++; $display("FAIL midrst_first_word: got c=%0d d=%h exp c=2 d=7e", count, out_data);
    end
    out_ready = 1'b1;
    step();
    tests_run++;
    if (out_data !== 8'h3C) begin fails++; $display("FAIL midrst_second_word: got %h exp 3c", out_data); end
    step();
    tests_run++;
    if (count !== 3'd0) begin fails++; $display("FAIL midrst_end_count: got %0d exp 0", count); end
    out_ready = 1'b0;
  endtask

  initial begin
    tests_run = 0;
    fails     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    #2;
    test_reset();
    test_fill_drain();
    test_wrap();
    test_full_pop();
    test_backpressure();
    test_midop_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/jbuffer_fifo.md
JBUFFER_FIFO -- requirements
Module: jbuffer_fifo

Interface
REQ-001 Parameter WIDTH, default 8, data width in bits; legal range >= 1.
REQ-002 Parameter DEPTH, default 4, number of entries; power of two, >= 2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_data  input  WIDTH  write data.
REQ-006 in_valid  input  1  write request.
REQ-007 in_ready  output  1  buffer can accept a word this cycle.
REQ-008 out_data  output  WIDTH  head-of-buffer data.
REQ-009 out_valid  output  1  out_data holds a valid word.
REQ-010 out_ready  input  1  consumer accepts the head word.
REQ-011 count  output  $clog2(DEPTH)+1  number of words held.

Function
REQ-012 Push occurs on a rising edge where in_valid && in_ready; in_data is written at wr_ptr, wr_ptr advances by 1.
REQ-013 Pop occurs on a rising edge where out_valid && out_ready; rd_ptr advances by 1.
REQ-014 wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap DEPTH-1 -> 0 with no gap or stall.
REQ-015 count: +1 on push only, -1 on pop only, unchanged on push+pop or neither.
REQ-016 in_ready = rst_n && (count != DEPTH); combinational from registered state, independent of in_valid.
REQ-017 out_valid = (count != 0); out_data = mem[rd_ptr] when out_valid, all-zero otherwise.
REQ-018 Latency: word pushed at edge N is visible on out_data/out_valid after edge N (usable at edge N+1); no same-cycle pass-through when empty.
REQ-019 Full (count == DEPTH): in_ready = 0, in_valid ignored, no data overwritten; a pop in that cycle still occurs, and in_ready = 1 the following cycle.
REQ-020 Empty (count == 0): out_valid = 0, out_ready ignored, count never underflows.
REQ-021 Simultaneous push and pop with 0 < count < DEPTH: both occur, count unchanged, order preserved.
REQ-022 While out_valid && !out_ready, out_data is held stable until popped.
REQ-023 Output order equals input order (strict FIFO); no word lost or duplicated.
REQ-024 Storage array is not reset; only pointers and count carry reset values.

Reset
REQ-025 On a rising edge with rst_n = 0: wr_ptr = 0, rd_ptr = 0, count = 0.
REQ-026 While rst_n = 0: in_ready = 0; after the reset edge: out_valid = 0, out_data = 0, count = 0.
REQ-027 Reset asserted mid-operation discards all held words; no push or pop occurs at that edge regardless of in_valid/out_ready.
REQ-028 First edge with rst_n = 1 after reset accepts a push if in_valid = 1.

Verification (WIDTH=8, DEPTH=4)
REQ-029 Reset: rst_n=0 two cycles, in_valid=1 -> count=0, out_valid=0, out_data=0x00, in_ready=0 during reset, 1 after release.
REQ-030 Fill/drain: push 0x11,0x22,0x33,0x44 with out_ready=0 -> count=4, in_ready=0; push of 0x55 ignored; then out_ready=1 -> out_data 0x11,0x22,0x33,0x44 on consecutive cycles, count=0.
REQ-031 Wrap: 10 words 0x00..0x09 with in_valid=1, out_ready=1 continuous -> output 0x00..0x09 in order, count stays 1 after first push, pointers wrap twice.
REQ-032 Full + pop: count=4, in_valid=1, out_ready=1 -> pop only, count=3; next cycle push+pop, count stays 3.
REQ-033 Backpressure: head 0xA5, out_ready=0 five cycles -> out_data=0xA5 and out_valid=1 held every cycle.
REQ-034 Mid-op reset: count=3, assert rst_n=0 one cycle -> count=0, out_valid=0; next push 0x7E is first word out.
